decode_sequencer: RTL

//  Next-generation instruction decoder for the ALU datapath: accepts opcode+operand words over a

---
 rtl/decode_sequencer_pkg.sv | 34 +++
 rtl/decode_sequencer_opcode_lut.sv | 61 ++++++
 rtl/decode_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/decode_sequencer_pkg.sv
// Shared types for the decode sequencer: opcodes, FSM state encodings and the control strobe bundle.
package decoder_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MOV  = 3'd1,
        OP_MAC  = 3'd2,
        OP_WAIT = 3'd3,
        OP_SETR = 3'd4,
        OP_LDSW = 3'd5
    } opcode_e;

    typedef logic [1:0] state_e;
    localparam state_e S_IDLE = 2'd0;
    localparam state_e S_WAIT = 2'd1;
    localparam state_e S_LOAD = 2'd2;

    typedef struct packed {
        logic f_add;
        logic f_wait;
        logic f_load;
        logic wr_res;
    } ctrl_t;

    function automatic ctrl_t mk_ctrl(input logic add, input logic wt, input logic ld, input logic wr);
        ctrl_t c;
        c.f_add  = add;
        c.f_wait = wt;
        c.f_load = ld;
        c.wr_res = wr;
        return c;
    endfunction

endpackage

// File: rtl/decode_sequencer_opcode_lut.sv
// Combinational decode of one instruction into its first-cycle strobes and the number of extra
// cycles (and the state to spend them in) that a multi-cycle op needs.
module opcode_lut
    import decoder_pkg::*;
#(
    parameter int                OPCODE_WIDTH  = 3,
    parameter int                OPERAND_WIDTH = 8,
    parameter int                NUM_REGS      = 5,
    parameter logic [NUM_REGS-1:0] MAC_MASK    = 5'b00101,
    parameter int                LOAD_CYCLES   = 2,
    parameter int                CNT_W         = 8
) (
    input  logic [OPCODE_WIDTH-1:0]  i_opcode,
    input  logic [OPERAND_WIDTH-1:0] i_operand,
    output ctrl_t                    o_ctrl,
    output logic [NUM_REGS-1:0]      o_reg_en,
    output logic                     o_illegal,
    output logic [CNT_W-1:0]         o_hold,
    output state_e                   o_hold_state
);

    logic w_idx_ok;
    assign w_idx_ok = (32'(i_operand) < NUM_REGS);

    always_comb begin
        o_ctrl       = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        o_reg_en     = '0;
        o_illegal    = 1'b0;
        o_hold       = '0;
        o_hold_state = S_IDLE;
        case (i_opcode)
            OPCODE_WIDTH'(OP_NOP): ;
            OPCODE_WIDTH'(OP_MOV): begin
                o_ctrl   = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1);
                o_reg_en = '1;
            end
            OPCODE_WIDTH'(OP_MAC): begin
                o_ctrl   = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1);
                o_reg_en = MAC_MASK;
            end
            OPCODE_WIDTH'(OP_WAIT): begin
                // WAIT 0 behaves as WAIT 1, so only counts above one need extra cycles
                o_ctrl       = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
                o_hold       = (i_operand == '0) ? '0 : CNT_W'(i_operand) - CNT_W'(1);
                o_hold_state = S_WAIT;
            end
            OPCODE_WIDTH'(OP_SETR): begin
                o_reg_en  = w_idx_ok ? (NUM_REGS'(1) << i_operand) : '0;
                o_illegal = !w_idx_ok;
            end
            OPCODE_WIDTH'(OP_LDSW): begin
                o_ctrl       = mk_ctrl(1'b1, 1'b0, 1'b1, LOAD_CYCLES == 1);
                o_reg_en     = '1;
                o_hold       = CNT_W'(LOAD_CYCLES - 1);
                o_hold_state = S_LOAD;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_sequencer.sv
// Instruction sequencer: accepts opcode/operand words over valid/ready and drives registered
// ALU control strobes, stretching WAIT and LDSW over several cycles with a down-counter.
module decode_sequencer
    import decoder_pkg::*;
#(
    parameter int                  OPCODE_WIDTH  = 3,
    parameter int                  OPERAND_WIDTH = 8,
    parameter int                  NUM_REGS      = 5,
    parameter logic [NUM_REGS-1:0] MAC_MASK      = 5'b00101,
    parameter int                  LOAD_CYCLES   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [OPCODE_WIDTH-1:0]  i_in_opcode,
    input  logic [OPERAND_WIDTH-1:0] i_in_operand,
    input  logic                     i_flush,
    output logic                     o_f_add,
    output logic                     o_f_wait,
    output logic                     o_f_load,
    output logic                     o_wr_res,
    output logic [NUM_REGS-1:0]      o_alu_reg_en,
    output logic                     o_illegal
);

    localparam int LC_W  = $clog2(LOAD_CYCLES) + 1;
    localparam int CNT_W = (OPERAND_WIDTH > LC_W) ? OPERAND_WIDTH : LC_W;

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    ctrl_t               r_ctrl;
    logic [NUM_REGS-1:0] r_reg_en;
    logic                r_illegal;

    ctrl_t               w_ctrl;
    logic [NUM_REGS-1:0] w_reg_en;
    logic                w_illegal;
    logic [CNT_W-1:0]    w_hold;
    state_e              w_hold_state;
    logic                w_ready;
    logic                w_accept;
    logic                w_last;

    assign w_ready    = (r_state == S_IDLE) && !i_flush;
    assign w_accept   = i_in_valid && w_ready;
    assign w_last     = (r_cnt == CNT_W'(1));
    assign o_in_ready = w_ready;

    opcode_lut #(
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .OPERAND_WIDTH(OPERAND_WIDTH),
        .NUM_REGS     (NUM_REGS),
        .MAC_MASK     (MAC_MASK),
        .LOAD_CYCLES  (LOAD_CYCLES),
        .CNT_W        (CNT_W)
    ) u_lut (
        .i_opcode    (i_in_opcode),
        .i_operand   (i_in_operand),
        .o_ctrl      (w_ctrl),
        .o_reg_en    (w_reg_en),
        .o_illegal   (w_illegal),
        .o_hold      (w_hold),
        .o_hold_state(w_hold_state)
    );

    // r_cnt counts output cycles still owed after the current one; the last one is spent in
    // S_IDLE so the following instruction can be accepted without a bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ctrl    <= mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
            r_reg_en  <= '0;
            r_illegal <= 1'b0;
        end else if (i_flush) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ctrl    <= mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
            r_reg_en  <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ctrl    <= w_ctrl;
                        r_reg_en  <= w_reg_en;
                        r_illegal <= w_illegal;
                        r_cnt     <= w_hold;
                        r_state   <= (w_hold != '0) ? w_hold_state : S_IDLE;
                    end else begin
                        r_ctrl    <= mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
                        r_reg_en  <= '0;
                        r_illegal <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_ctrl    <= mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
                    r_reg_en  <= '0;
                    r_illegal <= 1'b0;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    r_state   <= w_last ? S_IDLE : S_WAIT;
                end
                S_LOAD: begin
                    r_ctrl    <= mk_ctrl(1'b1, 1'b0, 1'b1, w_last);
                    r_reg_en  <= '1;
                    r_illegal <= 1'b0;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    r_state   <= w_last ? S_IDLE : S_LOAD;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_ctrl    <= mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
                    r_reg_en  <= '0;
                    r_illegal <= 1'b0;
                end
            endcase
        end
    end

    assign o_f_add      = r_ctrl.f_add;
    assign o_f_wait     = r_ctrl.f_wait;
    assign o_f_load     = r_ctrl.f_load;
    assign o_wr_res     = r_ctrl.wr_res;
    assign o_alu_reg_en = r_reg_en;
    assign o_illegal    = r_illegal;

endmodule
